// File: rtl/mostrar_resultado.sv
// mostrar_resultado: shows a signed 16-bit Booth product in decimal on an
// 8-digit multiplexed seven-segment display.
//   - Binary-to-BCD conversion is sequential double-dabble, one shift per cycle.
//   - Display registers are loaded only when a conversion completes.
//   - Digit scan: a counter over 0..REFRESH_DIV advances the digit index.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// 4..1. Digit 0 is always shown.
// Handshake: producto is accepted on a rising edge where listo=1 and
// producto_valido=1. A strobe while listo=0 is dropped; it is never queued.
module mostrar_resultado #(
    parameter int REFRESH_DIV = 99999
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [15:0] producto,
    input  logic        producto_valido,
    output logic        listo,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mag_q, mag_d;
    logic [19:0] bcd_q, bcd_d;
    logic        sign_q, sign_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [19:0] disp_bcd_q, disp_bcd_d;
    logic        disp_sign_q, disp_sign_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [19:0] bcd_adj;

    // Active-low segment pattern for one decimal digit; codes above 9 blank.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Segment pattern for a display position, given the shown value and sign.
    function automatic logic [6:0] digit_seg(input logic [2:0]  idx,
                                             input logic [19:0] bcd,
                                             input logic        sign);
        logic [6:0] s;
        logic       blank;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            3'd4:    blank = (bcd[19:16] == 4'd0);
            3'd3:    blank = (bcd[19:12] == 8'd0);
            3'd2:    blank = (bcd[19:8]  == 12'd0);
            3'd1:    blank = (bcd[19:4]  == 16'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        case (idx)
            3'd7, 3'd6: s = 7'b1111111;
            3'd5:       s = sign ? 7'b0111111 : 7'b1111111;
            default:    s = blank ? 7'b1111111 : hex_to_seg(bcd[idx*4 +: 4]);
        endcase
        return s;
    endfunction

    // Conversion FSM: next state, double-dabble step and display load.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        bit_cnt_d   = bit_cnt_q;
        disp_bcd_d  = disp_bcd_q;
        disp_sign_d = disp_sign_q;
        bcd_adj     = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (producto_valido) begin
                    sign_d    = producto[15];
                    mag_d     = producto[15] ? (~producto + 16'd1) : producto;
                    bcd_d     = 20'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                bcd_d     = {bcd_adj[18:0], mag_q[15]};
                mag_d     = {mag_q[14:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_bcd_d  = bcd_q;
                disp_sign_d = sign_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan: counter, index, and registered anode/segment drive.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        digit_d    = digit_q;
        if (scan_cnt_q == CW'(REFRESH_DIV)) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 3'd1;
        end
        an_d  = ~(8'b0000_0001 << digit_d);
        seg_d = digit_seg(digit_d, disp_bcd_d, disp_sign_d);
    end

    // State register for conversion, display and scan logic.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q     <= IDLE;
            mag_q       <= 16'd0;
            bcd_q       <= 20'd0;
            sign_q      <= 1'b0;
            bit_cnt_q   <= 4'd0;
            disp_bcd_q  <= 20'd0;
            disp_sign_q <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= 3'd0;
            an_q        <= 8'b1111_1110;
            seg_q       <= 7'b1000000;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            bit_cnt_q   <= bit_cnt_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_sign_q <= disp_sign_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign listo = (state_q == IDLE);
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_mostrar_resultado.sv
// Directed bench for mostrar_resultado with REFRESH_DIV=3.
module tb_mostrar_resultado;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] producto;
    logic        producto_valido;
    logic        listo;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    mostrar_resultado #(.REFRESH_DIV(3)) dut (
        .CLK100MHZ       (clk),
        .reset           (reset),
        .producto        (producto),
        .producto_valido (producto_valido),
        .listo           (listo),
        .an              (an),
        .seg             (seg),
        .dp              (dp)
    );

    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [6:0] num_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected pattern at position idx for a displayed value (BCD) and sign.
    function automatic logic [6:0] exp_seg(input int idx, input logic [19:0] bcd, input logic sign);
        logic [19:0] v;
        v = bcd;
        if (idx >= 6) return 7'h7F;
        if (idx == 5) return sign ? 7'b0111111 : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx >= 1 && (v >> (idx * 4)) == 20'd0) return 7'h7F;
`endif
        return num_seg(int'((v >> (idx * 4)) & 20'hF));
    endfunction

    function automatic int an_idx(input logic [7:0] a);
        for (int i = 0; i < 8; i++) if (a == ~(8'd1 << i)) return i;
        return 0;
    endfunction

    task automatic read_digit(input int idx, output logic [6:0] s);
        logic [7:0] target;
        target = ~(8'd1 << idx);
        for (int n = 0; n < 40 && an !== target; n++) tick();
        if (an !== target) check("scan_timeout", {24'd0, an}, {24'd0, target});
        s = seg;
    endtask

    task automatic check_display(input string tag, input logic [19:0] bcd, input logic sign);
        logic [6:0] s;
        for (int i = 0; i < 8; i++) begin
            read_digit(i, s);
            check($sformatf("%s_d%0d", tag, i), {25'd0, s}, {25'd0, exp_seg(i, bcd, sign)});
        end
    endtask

    // Strobe a product and follow it to completion; optionally re-strobe at k+5.
    task automatic run_conv(input string tag, input logic [15:0] p,
                            input logic [19:0] pbcd, input logic psign,
                            input logic [19:0] nbcd, input logic nsign,
                            input bit late_en, input logic [15:0] late_p);
        producto = p;
        producto_valido = 1'b1;
        tick();
        producto_valido = 1'b0;
        check({tag, "_listo_k"}, {31'd0, listo}, 32'd0);
        for (int j = 1; j <= 16; j++) begin
            if (late_en && j == 5) begin
                producto = late_p;
                producto_valido = 1'b1;
            end
            tick();
            producto_valido = 1'b0;
            check($sformatf("%s_listo_k%0d", tag, j), {31'd0, listo}, 32'd0);
            check($sformatf("%s_hold_k%0d", tag, j), {25'd0, seg},
                  {25'd0, exp_seg(an_idx(an), pbcd, psign)});
        end
        tick();
        check({tag, "_listo_k17"}, {31'd0, listo}, 32'd1);
        check({tag, "_seg_k17"}, {25'd0, seg}, {25'd0, exp_seg(an_idx(an), nbcd, nsign)});
        check_display(tag, nbcd, nsign);
    endtask

    initial begin
        reset = 1'b1;
        producto = 16'd0;
        producto_valido = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_listo", {31'd0, listo}, 32'd1);
        check("rst_an", {24'd0, an}, 32'hFE);
        check("rst_seg", {25'd0, seg}, 32'h40);
        check("rst_dp", {31'd0, dp}, 32'd1);

        // Scan sequence: one digit step every 4 cycles, wrapping after digit 7.
        for (int n = 1; n <= 32; n++) begin
            int d;
            tick();
            d = (n / 4) % 8;
            check($sformatf("scan_an_%0d", n), {24'd0, an}, {24'd0, ~(8'd1 << d)});
            check($sformatf("scan_seg_%0d", n), {25'd0, seg}, {25'd0, exp_seg(d, 20'd0, 1'b0)});
        end
        check("scan_listo", {31'd0, listo}, 32'd1);

        run_conv("neg42",   16'hFFD6, 20'h00000, 1'b0, 20'h00042, 1'b1, 1'b0, 16'd0);
        run_conv("p16384",  16'h4000, 20'h00042, 1'b1, 20'h16384, 1'b0, 1'b0, 16'd0);
        run_conv("n32768",  16'h8000, 20'h16384, 1'b0, 20'h32768, 1'b1, 1'b0, 16'd0);
        run_conv("ignore9", 16'h0007, 20'h32768, 1'b1, 20'h00007, 1'b0, 1'b1, 16'h0009);

        // Reset mid-conversion: abort, no display of 4660, back to reset values.
        producto = 16'h1234;
        producto_valido = 1'b1;
        tick();
        producto_valido = 1'b0;
        for (int j = 1; j <= 7; j++) tick();
        check("abort_busy", {31'd0, listo}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_listo", {31'd0, listo}, 32'd1);
        check("abort_an", {24'd0, an}, 32'hFE);
        check("abort_seg", {25'd0, seg}, 32'h40);
        for (int j = 0; j < 20; j++) tick();
        check("abort_idle", {31'd0, listo}, 32'd1);
        check_display("abort", 20'h00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mostrar_resultado.md
MOSTRAR_RESULTADO -- requirements
Module: mostrar_resultado

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 99999; it is the digit-scan terminal count, giving a 1 kHz digit rate and a 125 Hz frame at 100 MHz.
REQ-002 SHALL have port CLK100MHZ  input  1  system clock, 100 MHz.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port producto  input  16  signed two's-complement Booth product.
REQ-005 SHALL have port producto_valido  input  1  one-cycle strobe: producto is valid.
REQ-006 SHALL have port listo  output  1  high when idle and able to accept a product.
REQ-007 SHALL have port an  output  8  digit anodes, active-low; bit i selects digit i (0 = rightmost).
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low; tied to 1 (off).

Function
REQ-010 SHALL use one clock with all state updated on the CLK100MHZ rising edge; reset is synchronous and active-high.
REQ-011 SHALL implement FSM states IDLE, CONV and DONE; listo = (state == IDLE).
REQ-012 In IDLE with producto_valido=1, SHALL latch sign = producto[15] and magnitude = |producto| as a 16-bit unsigned value (-32768 -> 32768), clear the 20-bit BCD accumulator, and enter CONV.
REQ-013 CONV SHALL run double-dabble, one shift per cycle, for exactly 16 cycles: add 3 to each BCD nibble >= 5, then shift left by one with the magnitude MSB entering.
REQ-014 After the 16th shift, SHALL enter DONE; DONE SHALL copy the BCD result (5 digits) and sign into the display registers, then return to IDLE.
REQ-015 Latency: accept at edge k; display registers update at edge k+17; listo is low from k+1 through k+17 and high again after edge k+17.
REQ-016 producto_valido outside IDLE SHALL be ignored: no queueing and no effect on the conversion in progress.
REQ-017 Display registers SHALL hold the previous result until DONE; they never show partial conversion values.
REQ-018 Scan counter SHALL count 0..REFRESH_DIV; at terminal count it wraps to 0 and the digit index advances 0..7, wrapping 7 -> 0.
REQ-019 an SHALL be a one-hot-low decode of the digit index; exactly one bit is low at all times after reset.
REQ-020 Digit mapping: digits 7-6 blank; digit 5 = minus sign (seg=7'b0111111) if sign=1, else blank; digits 4..0 = BCD ten-thousands..units.
REQ-021 Blank digit SHALL drive seg=7'b1111111; the anode is still cycled.
REQ-022 Hex codes 0-9 SHALL map to standard active-low patterns (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000); nibbles >9 are unreachable and drive blank.
REQ-023 seg and an SHALL be registered, changing on the same edge as the digit index.

Reset
REQ-024 On reset: state IDLE, listo=1, scan counter 0, digit index 0, an=8'b11111110.
REQ-025 On reset: display BCD = 0, sign = 0, so the display shows "0" in digit 0; digit 0 seg=7'b1000000.
REQ-026 Reset during CONV or DONE SHALL abort the conversion with no display update and return to the REQ-024/025 values on the next edge.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: each magnitude digit 4..1 whose value and all more-significant magnitude digits are zero SHALL display blank; digit 0 is always shown; the sign stays in digit 5.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: digits 4..0 SHALL always show their value, including leading zeros (e.g. "00042").

Verification (REFRESH_DIV=3 in simulation)
REQ-029 Reset, run 32 cycles -> listo=1; an sequence FE,FD,FB,...,7F, one step every 4 cycles, then wraps to FE; digit 0 seg=7'b1000000, digit 5 blank.
REQ-030 producto=16'hFFD6 (-42) strobed at edge k -> listo low k+1..k+17; at k+17 digits 4..0 = 0,0,0,4,2 (blank,blank,blank,4,2 with macro) and digit 5 = minus.
REQ-031 producto=16'h4000 (16384, i.e. -128*-128) -> digits 1,6,3,8,4; digit 5 blank.
REQ-032 producto=16'h8000 -> digits 3,2,7,6,8; digit 5 = minus (magnitude 32768, no overflow).
REQ-033 Strobe 16'h0007, then strobe 16'h0009 five cycles later -> second strobe ignored; display shows 7 and listo remains low until k+17.
REQ-034 Strobe 16'h1234, then assert reset at k+8 -> next edge listo=1, display "0", an=FE; 4660 never displayed.
